riscv_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch requester (PC side) and the load/store requester (ALU/MemRW side) of the RISC-V datapath.
- Owns the memory handshake:
  - captures one request;
  - holds it on the memory port until acknowledged or timed out;
  - returns the completion to the owning requester.
- Sits between the datapath and the memory model, below riscv_top.

---
 rtl/riscv_mem_pkg.sv | 19 +
 rtl/riscv_mem_timeout_cnt.sv | 27 ++
 rtl/riscv_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, owner tags and
// default bus widths.
package riscv_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/riscv_mem_timeout_cnt.sv
// Up-counter with synchronous clear and enable; tc is high while the count
// sits at TERM-1.
module riscv_mem_timeout_cnt #(
  parameter int TERM = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TERM);

  logic [CW-1:0] count;

  assign tc = (count == CW'(TERM - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates the fetch and load/store requesters onto one single-ported memory,
// owning one outstanding memory transaction at a time.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 16,
  parameter int DATA_PRIO   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        fsm_state
);

  // Handshake: requesters hold req until their gnt pulse; m_req is held with
  // stable m_* until m_ack or timeout; the completion is returned one cycle
  // after m_req drops, which is also the earliest cycle of the next gnt.

  state_t            state;
  owner_t            last_owner;
  logic              pend;
  logic              pend_d;
  logic              pend_err;
  logic [DATA_W-1:0] pend_data;
  logic              busy;
  logic              tc;
  logic              grant_i;
  logic              grant_d;

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  riscv_mem_timeout_cnt #(
    .TERM (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!busy),
    .en    (busy),
    .tc    (tc)
  );

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_req && i_req) begin
        // Round-robin on ties favours whoever did not own the last transaction.
        if (DATA_PRIO != 0 || last_owner == OWN_I) begin
          grant_d = 1'b1;
        end else begin
          grant_i = 1'b1;
        end
      end else begin
        grant_d = d_req;
        grant_i = i_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWN_D;
      pend       <= 1'b0;
      pend_d     <= 1'b0;
      pend_err   <= 1'b0;
      pend_data  <= '0;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= 4'b0000;
    end else begin
      i_gnt    <= grant_i;
      d_gnt    <= grant_d;
      i_rvalid <= pend && !pend_d;
      d_rvalid <= pend && pend_d;
      err      <= pend && pend_err;
      i_rdata  <= (pend && !pend_d) ? pend_data : '0;
      d_rdata  <= (pend && pend_d) ? pend_data : '0;
      pend     <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_d) begin
            m_req      <= 1'b1;
            m_we       <= d_we;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            m_wstrb    <= d_wstrb;
            last_owner <= OWN_D;
            state      <= BUSY_D;
          end else if (grant_i) begin
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= '0;
            m_wstrb    <= 4'b0000;
            last_owner <= OWN_I;
            state      <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          // An ack on the terminal-count cycle still completes normally.
          if (m_ack || tc) begin
            m_req     <= 1'b0;
            pend      <= 1'b1;
            pend_d    <= (state == BUSY_D);
            pend_err  <= !m_ack;
            pend_data <= (m_ack && !(state == BUSY_D && m_we)) ? m_rdata : '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: a data-priority instance for most
// scenarios and a round-robin instance for tie alternation.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wstrb;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, err, m_req, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  fsm_state;

  logic        i_req_r, d_req_r, m_ack_r;
  logic        i_gnt_r, i_rvalid_r, d_gnt_r, d_rvalid_r, err_r, m_req_r, m_we_r;
  logic [31:0] i_rdata_r, d_rdata_r, m_addr_r, m_wdata_r;
  logic [3:0]  m_wstrb_r;
  logic [1:0]  fsm_state_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.TIMEOUT_CYC(16), .DATA_PRIO(1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata), .fsm_state(fsm_state)
  );

  riscv_mem_arbiter #(.TIMEOUT_CYC(16), .DATA_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset),
    .i_req(i_req_r), .i_addr(i_addr), .i_gnt(i_gnt_r), .i_rvalid(i_rvalid_r), .i_rdata(i_rdata_r),
    .d_req(d_req_r), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt_r), .d_rvalid(d_rvalid_r), .d_rdata(d_rdata_r), .err(err_r),
    .m_req(m_req_r), .m_we(m_we_r), .m_addr(m_addr_r), .m_wdata(m_wdata_r), .m_wstrb(m_wstrb_r),
    .m_ack(m_ack_r), .m_rdata(m_rdata), .fsm_state(fsm_state_r)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
    i_req_r = 0; d_req_r = 0; m_ack_r = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; m_rdata = 0;
    step();
    step();
    check("rst_m_req", {31'b0, m_req}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_flags", {26'b0, i_gnt, d_gnt, i_rvalid, d_rvalid, err, m_we}, 32'd0);
    check("rst_state", {30'b0, fsm_state}, 32'd0);
    reset = 1'b0;

    // Single fetch
    i_req = 1; i_addr = 32'h100;
    step();
    check("f_gnt", {31'b0, i_gnt}, 32'd1);
    check("f_m_req", {31'b0, m_req}, 32'd1);
    check("f_m_addr", m_addr, 32'h100);
    check("f_m_we", {31'b0, m_we}, 32'd0);
    check("f_state", {30'b0, fsm_state}, 32'd1);
    i_req = 0;
    step();
    check("f_gnt_pulse", {31'b0, i_gnt}, 32'd0);
    step();
    m_ack = 1; m_rdata = 32'h00500093;
    step();
    m_ack = 0;
    check("f_m_req_drop", {31'b0, m_req}, 32'd0);
    check("f_rvalid_early", {31'b0, i_rvalid}, 32'd0);
    step();
    check("f_rvalid", {31'b0, i_rvalid}, 32'd1);
    check("f_rdata", i_rdata, 32'h00500093);
    check("f_err", {31'b0, err}, 32'd0);
    step();
    check("f_rvalid_pulse", {31'b0, i_rvalid}, 32'd0);

    // Store
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    step();
    check("s_gnt", {31'b0, d_gnt}, 32'd1);
    check("s_m_we", {31'b0, m_we}, 32'd1);
    check("s_m_wstrb", {28'b0, m_wstrb}, 32'h3);
    d_req = 0; d_wdata = 32'h0; d_wstrb = 4'b0000; d_addr = 32'h0;
    step();
    check("s_wdata_hold", m_wdata, 32'hDEADBEEF);
    check("s_wstrb_hold", {28'b0, m_wstrb}, 32'h3);
    check("s_addr_hold", m_addr, 32'h2000);
    m_ack = 1; m_rdata = 32'h12345678;
    step();
    m_ack = 0;
    check("s_m_req_drop", {31'b0, m_req}, 32'd0);
    step();
    check("s_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("s_rdata_zero", d_rdata, 32'd0);
    check("s_no_i_rvalid", {31'b0, i_rvalid}, 32'd0);

    // Tie with data priority; fetch is granted alongside d_rvalid
    d_we = 0;
    i_req = 1; i_addr = 32'h104; d_req = 1; d_addr = 32'h3000;
    step();
    check("t_d_gnt", {31'b0, d_gnt}, 32'd1);
    check("t_i_not_gnt", {31'b0, i_gnt}, 32'd0);
    check("t_m_addr", m_addr, 32'h3000);
    d_req = 0;
    m_ack = 1; m_rdata = 32'hCAFE0001;
    step();
    m_ack = 0;
    step();
    check("t_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("t_d_rdata", d_rdata, 32'hCAFE0001);
    check("t_i_gnt_same", {31'b0, i_gnt}, 32'd1);
    check("t_i_m_addr", m_addr, 32'h104);
    i_req = 0;
    m_ack = 1; m_rdata = 32'h0000AAAA;
    step();
    m_ack = 0;
    step();
    check("t_i_rvalid", {31'b0, i_rvalid}, 32'd1);
    check("t_i_rdata", i_rdata, 32'h0000AAAA);
    check("t_no_d_rvalid", {31'b0, d_rvalid}, 32'd0);

    // Round-robin instance: D first, then continuous ties alternate I, D, I, D
    d_req_r = 1; d_addr = 32'h3000; i_addr = 32'h108;
    step();
    check("rr_first_d", {31'b0, d_gnt_r}, 32'd1);
    d_req_r = 0;
    m_ack_r = 1; m_rdata = 32'h11;
    step();
    m_ack_r = 0;
    step();
    check("rr_d_rvalid", {31'b0, d_rvalid_r}, 32'd1);
    check("rr_d_rdata", d_rdata_r, 32'h11);
    i_req_r = 1; d_req_r = 1;
    step();
    check("rr_tie_i", {31'b0, i_gnt_r}, 32'd1);
    check("rr_tie_not_d", {31'b0, d_gnt_r}, 32'd0);
    check("rr_tie_addr", m_addr_r, 32'h108);
    for (int k = 0; k < 3; k++) begin
      m_ack_r = 1;
      step();
      m_ack_r = 0;
      step();
      check("rr_alt_d", {31'b0, d_gnt_r}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_alt_i", {31'b0, i_gnt_r}, (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    i_req_r = 0; d_req_r = 0;
    m_ack_r = 1;
    step();
    m_ack_r = 0;
    step();

    // Timeout on a load with no ack
    m_rdata = 32'hFFFFFFFF;
    d_req = 1; d_we = 0; d_addr = 32'h4000;
    step();
    check("to_gnt", {31'b0, d_gnt}, 32'd1);
    d_req = 0;
    for (int k = 0; k < 15; k++) step();
    check("to_m_req_16", {31'b0, m_req}, 32'd1);
    check("to_state_busy", {30'b0, fsm_state}, 32'd2);
    step();
    check("to_m_req_drop", {31'b0, m_req}, 32'd0);
    check("to_state_idle", {30'b0, fsm_state}, 32'd0);
    step();
    check("to_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("to_err", {31'b0, err}, 32'd1);
    check("to_rdata", d_rdata, 32'd0);
    m_ack = 1;
    step();
    m_ack = 0;
    check("late_ack_rvalid", {31'b0, d_rvalid}, 32'd0);
    check("late_ack_err", {31'b0, err}, 32'd0);
    step();
    check("late_ack_quiet", {29'b0, d_rvalid, i_rvalid, err}, 32'd0);
    check("late_ack_m_req", {31'b0, m_req}, 32'd0);

    // Ack on the terminal-count cycle completes normally
    d_req = 1; d_addr = 32'h4004;
    step();
    d_req = 0;
    for (int k = 0; k < 15; k++) step();
    m_ack = 1; m_rdata = 32'h5A5A5A5A;
    step();
    m_ack = 0;
    check("tc_ack_m_req", {31'b0, m_req}, 32'd0);
    step();
    check("tc_ack_rvalid", {31'b0, d_rvalid}, 32'd1);
    check("tc_ack_err", {31'b0, err}, 32'd0);
    check("tc_ack_rdata", d_rdata, 32'h5A5A5A5A);

    // Reset in the second BUSY cycle
    i_req = 1; i_addr = 32'h200;
    step();
    check("rm_gnt", {31'b0, i_gnt}, 32'd1);
    step();
    reset = 1;
    i_addr = 32'h204;
    step();
    reset = 0;
    check("rm_m_req", {31'b0, m_req}, 32'd0);
    check("rm_m_addr", m_addr, 32'd0);
    check("rm_flags", {26'b0, i_gnt, d_gnt, i_rvalid, d_rvalid, err, m_we}, 32'd0);
    check("rm_state", {30'b0, fsm_state}, 32'd0);
    step();
    check("rm_regrant", {31'b0, i_gnt}, 32'd1);
    check("rm_regrant_addr", m_addr, 32'h204);
    check("rm_no_rvalid", {31'b0, i_rvalid}, 32'd0);
    i_req = 0;
    m_ack = 1; m_rdata = 32'h0BADF00D;
    step();
    m_ack = 0;
    step();
    check("rm_rvalid", {31'b0, i_rvalid}, 32'd1);
    check("rm_rdata", i_rdata, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
